// File: rtl/core_mem_arb_pkg.sv
// rtl/core_mem_arb_pkg.sv - shared types and defaults for the core memory arbiter
//
// Purpose: FSM state encoding, default NOP word and timeout sizing used by
//          core_mem_arbiter and core_mem_arb_watchdog.
// Ports:   none (package).

package core_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    DRESP = 2'd3
  } arb_state_e;

  localparam logic [31:0] NOP_INSN_DEF        = 32'h0000_0013;
  localparam int          DEF_TIMEOUT_CYCLES  = 256;
  localparam int          TIMEOUT_W           = $clog2(DEF_TIMEOUT_CYCLES + 1);

endpackage

// File: rtl/core_mem_arb_watchdog.sv
// rtl/core_mem_arb_watchdog.sv - bus transaction timeout counter
//
// Purpose: counts bus cycles that pass without mem_ready and flags expiry
//          on the CYCLES-th such cycle.
// Ports:
//   clk     in  clock, rising edge
//   rst     in  synchronous active-high reset
//   start   in  clear the count (a new transaction is being launched)
//   tick    in  one bus cycle elapsed without completion
//   expired out combinational; high in the cycle that is the CYCLES-th tick

module core_mem_arb_watchdog
  import core_mem_arb_pkg::*;
#(
  parameter int CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int W      = TIMEOUT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic tick,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] count;

  // count holds the number of ticks already seen, so the current tick is
  // the CYCLES-th one when count has reached CYCLES-1.
  assign expired = tick && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (tick && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - unified imem/dmem arbiter with one-entry fetch buffer
//
// Purpose: shares a single-port memory bus between the core's fetch and data
//          ports; the last fetched word is held in a one-entry buffer so the
//          core keeps decoding it while a data access is in flight.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   imem_req/addr                    core fetch request and PC
//   imem_rdata/ready/err             buffered instruction (NOP_INSN on miss)
//   dmem_req/we/be/addr/wdata        core data request
//   dmem_rdata/ready/err             registered load data, one-cycle done pulse
//   mem_req/we/be/addr/wdata         registered bus request
//   mem_rdata/ready/err              bus response

module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] NOP_INSN       = NOP_INSN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  output logic        imem_err,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [3:0]  dmem_be,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        mem_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e  state, state_n;

  logic        buf_valid;
  logic        buf_err;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;

  logic        hit;
  logic        start_data;
  logic        start_fetch;
  logic        wd_tick;
  logic        wd_expired;
  logic        txn_done;
  logic [31:0] rsp_data;
  logic        rsp_err;

  assign hit        = buf_valid && imem_req && (buf_addr == imem_addr);
  assign imem_ready = hit;
  assign imem_err   = hit && buf_err;
  // A miss must not present the old word, or the core would re-execute it.
  assign imem_rdata = hit ? buf_data : NOP_INSN;
  assign dmem_ready = (state == DRESP);

  // mem_req is only high in FETCH/DATA, so these are only meaningful there.
  // A real completion beats an expiry landing in the same cycle.
  assign wd_tick  = mem_req && !mem_ready;
  assign txn_done = mem_ready || wd_expired;
  assign rsp_data = mem_ready ? mem_rdata : 32'h0;
  assign rsp_err  = mem_ready ? mem_err   : 1'b1;

  core_mem_arb_watchdog #(
    .CYCLES (TIMEOUT_CYCLES),
    .W      (TW)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .start   (start_data || start_fetch),
    .tick    (wd_tick),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    start_data  = 1'b0;
    start_fetch = 1'b0;
    case (state)
      IDLE: begin
        // Data is only accepted while the core's current instruction is held
        // in the buffer; otherwise the request is ignored until it is.
        if (dmem_req && hit) begin
          start_data = 1'b1;
          state_n    = DATA;
        end else if (imem_req && !hit) begin
          start_fetch = 1'b1;
          state_n     = FETCH;
        end
      end
      FETCH:   if (txn_done) state_n = IDLE;
      DATA:    if (txn_done) state_n = DRESP;
      DRESP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'h0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      dmem_rdata <= 32'h0;
      dmem_err   <= 1'b0;
      buf_valid  <= 1'b0;
      buf_err    <= 1'b0;
      buf_addr   <= 32'h0;
      buf_data   <= 32'h0;
    end else begin
      if (start_data) begin
        mem_req   <= 1'b1;
        mem_we    <= dmem_we;
        mem_be    <= dmem_we ? dmem_be : 4'hF;
        mem_addr  <= dmem_addr;
        mem_wdata <= dmem_wdata;
      end else if (start_fetch) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_be    <= 4'hF;
        mem_addr  <= imem_addr;
        mem_wdata <= 32'h0;
      end

      if (state == FETCH && txn_done) begin
        mem_req   <= 1'b0;
        buf_valid <= 1'b1;
        buf_addr  <= mem_addr;
        buf_data  <= rsp_data;
        buf_err   <= rsp_err;
      end

      if (state == DATA && txn_done) begin
        mem_req    <= 1'b0;
        dmem_rdata <= rsp_data;
        dmem_err   <= rsp_err;
      end

      // The buffer survives DRESP so the core can advance its PC, but a
      // store over the buffered word forces a refetch afterwards.
      if (state == DRESP && mem_we && (mem_addr[31:2] == buf_addr[31:2])) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - self-checking bench for core_mem_arbiter

module tb_core_mem_arbiter;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .imem_err   (imem_err),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_be    (dmem_be),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .dmem_err   (dmem_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_err    (mem_err)
  );

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        m_err;
    logic        e_iready;
    logic [31:0] e_irdata;
    logic        e_ierr;
    logic        e_dready;
    logic [31:0] e_drdata;
    logic        e_derr;
    logic        e_mreq;
    logic        e_mwe;
    logic [3:0]  e_mbe;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    imem_req   = 1'b0;
    imem_addr  = 32'h0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = 4'h0;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;
    mem_rdata  = 32'h0;
    mem_ready  = 1'b0;
    mem_err    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // Bring the buffer to hold addr with the given word and error flag.
  task automatic fill(input logic [31:0] addr, input logic [31:0] data, input logic err);
    imem_req  = 1'b1;
    imem_addr = addr;
    step();
    mem_ready = 1'b1;
    mem_rdata = data;
    mem_err   = err;
    step();
    mem_ready = 1'b0;
    mem_err   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;

    // in: ireq iaddr dreq dwe dbe daddr dwdata mready mrdata merr
    // exp: iready irdata ierr dready drdata derr mreq mwe mbe maddr
    tbl[0]  = '{0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0, 0, 32'h0,        0,
                0, NOP,          0, 0, 32'h0,        0, 0, 0, 4'h0, 32'h0};
    tbl[1]  = '{1, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0, 0, 32'h0,        0,
                0, NOP,          0, 0, 32'h0,        0, 0, 0, 4'h0, 32'h0};
    tbl[2]  = '{1, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0, 1, 32'h00500093, 0,
                0, NOP,          0, 0, 32'h0,        0, 1, 0, 4'hF, 32'h0};
    tbl[3]  = '{1, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0, 0, 32'h0,        0,
                1, 32'h00500093, 0, 0, 32'h0,        0, 0, 0, 4'hF, 32'h0};
    tbl[4]  = '{1, 32'h0,   1, 0, 4'h0, 32'h100, 32'h0, 0, 32'h0,        0,
                1, 32'h00500093, 0, 0, 32'h0,        0, 0, 0, 4'hF, 32'h0};
    tbl[5]  = '{1, 32'h0,   1, 0, 4'h0, 32'h100, 32'h0, 0, 32'h0,        0,
                1, 32'h00500093, 0, 0, 32'h0,        0, 1, 0, 4'hF, 32'h100};
    tbl[6]  = '{1, 32'h0,   1, 0, 4'h0, 32'h100, 32'h0, 0, 32'h0,        0,
                1, 32'h00500093, 0, 0, 32'h0,        0, 1, 0, 4'hF, 32'h100};
    tbl[7]  = '{1, 32'h0,   1, 0, 4'h0, 32'h100, 32'h0, 0, 32'h0,        0,
                1, 32'h00500093, 0, 0, 32'h0,        0, 1, 0, 4'hF, 32'h100};
    tbl[8]  = '{1, 32'h0,   1, 0, 4'h0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0,
                1, 32'h00500093, 0, 0, 32'h0,        0, 1, 0, 4'hF, 32'h100};
    tbl[9]  = '{1, 32'h0,   1, 0, 4'h0, 32'h100, 32'h0, 0, 32'h0,        0,
                1, 32'h00500093, 0, 1, 32'hDEADBEEF, 0, 0, 0, 4'hF, 32'h100};
    tbl[10] = '{1, 32'h4,   0, 0, 4'h0, 32'h0,   32'h0, 0, 32'h0,        0,
                0, NOP,          0, 0, 32'hDEADBEEF, 0, 0, 0, 4'hF, 32'h100};
    tbl[11] = '{1, 32'h4,   0, 0, 4'h0, 32'h0,   32'h0, 0, 32'h0,        0,
                0, NOP,          0, 0, 32'hDEADBEEF, 0, 1, 0, 4'hF, 32'h4};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      imem_req   = tbl[i].i_req;
      imem_addr  = tbl[i].i_addr;
      dmem_req   = tbl[i].d_req;
      dmem_we    = tbl[i].d_we;
      dmem_be    = tbl[i].d_be;
      dmem_addr  = tbl[i].d_addr;
      dmem_wdata = tbl[i].d_wdata;
      mem_ready  = tbl[i].m_ready;
      mem_rdata  = tbl[i].m_rdata;
      mem_err    = tbl[i].m_err;
      @(negedge clk);
      chk($sformatf("v%0d imem_ready", i), imem_ready, tbl[i].e_iready);
      chk($sformatf("v%0d imem_rdata", i), imem_rdata, tbl[i].e_irdata);
      chk($sformatf("v%0d imem_err",   i), imem_err,   tbl[i].e_ierr);
      chk($sformatf("v%0d dmem_ready", i), dmem_ready, tbl[i].e_dready);
      chk($sformatf("v%0d dmem_rdata", i), dmem_rdata, tbl[i].e_drdata);
      chk($sformatf("v%0d dmem_err",   i), dmem_err,   tbl[i].e_derr);
      chk($sformatf("v%0d mem_req",    i), mem_req,    tbl[i].e_mreq);
      chk($sformatf("v%0d mem_we",     i), mem_we,     tbl[i].e_mwe);
      chk($sformatf("v%0d mem_be",     i), mem_be,     tbl[i].e_mbe);
      chk($sformatf("v%0d mem_addr",   i), mem_addr,   tbl[i].e_maddr);
      step();
    end

    // Store over the buffered word forces a refetch.
    do_reset();
    fill(32'h10, 32'h0000_0033, 1'b0);
    dmem_req   = 1'b1;
    dmem_we    = 1'b1;
    dmem_be    = 4'b0011;
    dmem_addr  = 32'h10;
    dmem_wdata = 32'hCAFE_F00D;
    step();
    @(negedge clk);
    chk("sw mem_we",    mem_we,    1'b1);
    chk("sw mem_be",    mem_be,    4'b0011);
    chk("sw mem_wdata", mem_wdata, 32'hCAFE_F00D);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw dresp imem_ready", imem_ready, 1'b1);
    chk("sw dresp dmem_ready", dmem_ready, 1'b1);
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    step();
    @(negedge clk);
    chk("sw after imem_ready", imem_ready, 1'b0);
    chk("sw after imem_rdata", imem_rdata, NOP);
    chk("sw after dmem_ready", dmem_ready, 1'b0);
    step();
    @(negedge clk);
    chk("sw refetch mem_req",  mem_req,  1'b1);
    chk("sw refetch mem_addr", mem_addr, 32'h10);
    chk("sw refetch mem_we",   mem_we,   1'b0);

    // Data access that never completes times out after 256 bus cycles.
    do_reset();
    fill(32'h0, 32'h0000_0013, 1'b0);
    dmem_req  = 1'b1;
    dmem_addr = 32'h200;
    mem_rdata = 32'h1234_5678;
    step();
    @(negedge clk);
    n = 0;
    while (mem_req && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("to req_cycles",  n,          256);
    chk("to dmem_ready",  dmem_ready, 1'b1);
    chk("to dmem_err",    dmem_err,   1'b1);
    chk("to dmem_rdata",  dmem_rdata, 32'h0);
    dmem_req = 1'b0;
    step();
    @(negedge clk);
    chk("to pulse_end", dmem_ready, 1'b0);

    // mem_ready on the very expiry cycle wins over the timeout.
    do_reset();
    fill(32'h0, 32'h0000_0013, 1'b0);
    dmem_req  = 1'b1;
    dmem_addr = 32'h300;
    step();
    for (int k = 0; k < 255; k++) step();
    @(negedge clk);
    chk("edge mem_req", mem_req, 1'b1);
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5_5A5A;
    step();
    mem_ready = 1'b0;
    dmem_req  = 1'b0;
    @(negedge clk);
    chk("edge dmem_ready", dmem_ready, 1'b1);
    chk("edge dmem_err",   dmem_err,   1'b0);
    chk("edge dmem_rdata", dmem_rdata, 32'hA5A5_5A5A);

    // Fetch error is held with the buffer; imem_req low keeps the buffer.
    do_reset();
    fill(32'h20, 32'h0000_0055, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ferr imem_ready c%0d", k), imem_ready, 1'b1);
      chk($sformatf("ferr imem_err c%0d", k),   imem_err,   1'b1);
      step();
    end
    imem_req = 1'b0;
    step();
    step();
    imem_req = 1'b1;
    @(negedge clk);
    chk("ferr kept imem_ready", imem_ready, 1'b1);
    chk("ferr kept mem_req",    mem_req,    1'b0);
    imem_addr = 32'h24;
    #1;
    chk("ferr other imem_ready", imem_ready, 1'b0);
    chk("ferr other imem_err",   imem_err,   1'b0);
    chk("ferr other imem_rdata", imem_rdata, NOP);

    // Reset in the middle of a data access.
    do_reset();
    fill(32'h0, 32'h0000_0013, 1'b0);
    dmem_req  = 1'b1;
    dmem_addr = 32'h100;
    step();
    @(negedge clk);
    chk("rst pre mem_req", mem_req, 1'b1);
    rst = 1'b1;
    step();
    rst      = 1'b0;
    dmem_req = 1'b0;
    @(negedge clk);
    chk("rst mem_req",    mem_req,    1'b0);
    chk("rst imem_ready", imem_ready, 1'b0);
    chk("rst imem_rdata", imem_rdata, NOP);
    chk("rst dmem_ready", dmem_ready, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
